// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: one 128-bit round key per clock.
// Ports: clk, rst (async high), start, key_in[255:0] -> round_key[14:0], busy, keys_valid.

module aes256_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Forward S-box packed MSB-first: entry 0 lives in bits [2047:2040].
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // msb index of entry a is 2047 - 8*a == {~a, 3'b111}
  assign y = TBL[{~a, 3'b111} -: 8];

endmodule

module aes256_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic [127:0] round_key [14:0],
  output logic         busy,
  output logic         keys_valid
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

  logic [0:0]   state;
  logic [3:0]   rc;
  logic [127:0] prev1;
  logic [127:0] prev2;
  logic [31:0]  t;
  logic [31:0]  sin;
  logic [31:0]  sout;
  logic [31:0]  temp;
  logic [7:0]   rcon;
  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;
  logic [127:0] next_key;

  always_comb begin
    prev1 = '0;
    prev2 = '0;
    for (int i = 2; i < 15; i++) begin
      if (rc == 4'(i)) begin
        prev1 = round_key[i-1];
        prev2 = round_key[i-2];
      end
    end
  end

  assign t = prev1[31:0];

  // Even rounds rotate before substitution; odd rounds substitute only.
  assign sin = rc[0] ? t : {t[23:0], t[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes256_sbox u_sbox (
      .a (sin[8*g +: 8]),
      .y (sout[8*g +: 8])
    );
  end

  // Rcon[rc/2] = 2^(rc/2 - 1); rc/2 spans 1..7 so no reduction needed.
  assign rcon = 8'h01 << (rc[3:1] - 3'd1);
  assign temp = rc[0] ? sout : (sout ^ {rcon, 24'h0});

  assign w0 = prev2[127:96] ^ temp;
  assign w1 = prev2[95:64]  ^ w0;
  assign w2 = prev2[63:32]  ^ w1;
  assign w3 = prev2[31:0]   ^ w2;
  assign next_key = {w0, w1, w2, w3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rc         <= 4'd2;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      for (int i = 0; i < 15; i++) begin
        round_key[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            round_key[0] <= key_in[255:128];
            round_key[1] <= key_in[127:0];
            rc           <= 4'd2;
            busy         <= 1'b1;
            keys_valid   <= 1'b0;
            state        <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 2; i < 15; i++) begin
            if (rc == 4'(i)) begin
              round_key[i] <= next_key;
            end
          end
          if (rc == 4'd14) begin
            rc         <= 4'd2;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
            state      <= IDLE;
          end else begin
            rc <= rc + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
